divu_unit: RTL and testbench

- Multi-cycle 32-bit unsigned divider for the TotalALU datapath. It is the inverse operation of the sequential MULTU path.
- Uses the same ALU-style control interface: 6-bit function code on Signal, operands on dataA/dataB, and a single Output bus.
- Quotient goes to LO and remainder goes to HI. Both are read back with MFHI/MFLO.
- Exercised by the same file-driven bench flow: issue DIVU, wait, then read HI and LO.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/div_step.sv | 33 +++
 rtl/divu_unit.sv | 166 ++++++++++++++++
 tb/tb_divu_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the TotalALU datapath: function codes, divider states, default width.
// Pure declarations; no logic, no latency.
// No flow control; imported by the divider and its iteration step.
package alu_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [5:0] FN_DIVU  = 6'd27;
   localparam logic [5:0] FN_DIV   = 6'd26;
   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MULTU = 6'd25;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, q} left, trial-subtract the divisor.
// Purely combinational, zero latency.
// No flow control; the caller registers the outputs once per cycle.
module div_step
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_trial;

   // The loop invariant rem < divisor keeps the trial inside (-divisor, divisor),
   // so WIDTH+1 bits are enough and the top bit is a valid sign.
   always_comb begin
      w_rem_sh = {i_rem, i_q[WIDTH-1]};
      w_trial  = w_rem_sh - {1'b0, i_divisor};
      if (!w_trial[WIDTH]) begin
         o_rem = w_trial[WIDTH-1:0];
         o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
         o_rem = w_rem_sh[WIDTH-1:0];
         o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/divu_unit.sv
// Multi-cycle restoring divider: quotient to LO, remainder to HI, read back via MFHI/MFLO.
// Results land 32 cycles after the start edge; Output is combinational from Signal and HI/LO.
// No backpressure: busy is informational, starts are ignored until the FSM is back in IDLE.
// Optional signed DIV (code 26) is built when DIVU_SIGNED_DIV_EN is defined.
module divu_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   output logic [WIDTH-1:0] Output,
   output logic             busy,
   output logic             div_zero
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       r_state;
   div_state_t       w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_div_zero;

   logic             w_start;
   logic             w_last;
   logic [WIDTH-1:0] w_a_op;
   logic [WIDTH-1:0] w_b_op;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_hi_fin;
   logic [WIDTH-1:0] w_lo_fin;

`ifdef DIVU_SIGNED_DIV_EN
   logic r_neg_q;
   logic r_neg_r;
   logic w_is_div;

   // Signed DIV iterates on magnitudes; signs are reapplied at completion.
   always_comb begin
      w_is_div = (Signal == FN_DIV);
      w_start  = (Signal == FN_DIVU) || w_is_div;
      w_a_op   = (w_is_div && dataA[WIDTH-1]) ? -dataA : dataA;
      w_b_op   = (w_is_div && dataB[WIDTH-1]) ? -dataB : dataB;
   end
`else
   // Only unsigned DIVU starts a division.
   always_comb begin
      w_start = (Signal == FN_DIVU);
      w_a_op  = dataA;
      w_b_op  = dataB;
   end
`endif

   assign w_last = (r_cnt == LAST_CNT);

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (r_rem),
      .i_q       (r_q),
      .i_divisor (r_div),
      .o_rem     (w_rem_nxt),
      .o_q       (w_q_nxt)
   );

   // Final HI/LO values taken from the last iteration's outputs.
   always_comb begin
      w_lo_fin = w_q_nxt;
      w_hi_fin = w_rem_nxt;
`ifdef DIVU_SIGNED_DIV_EN
      // Divide by zero keeps the all-ones quotient; remainder still carries the dividend sign,
      // which reproduces the original dividend.
      if (r_neg_q && (r_div != '0)) w_lo_fin = -w_q_nxt;
      if (r_neg_r)                  w_hi_fin = -w_rem_nxt;
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic; DONE waits for the start code to drop so a held code starts once.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next_state = RUN;
         RUN:     if (w_last)  w_next_state = DONE;
         DONE:    if (!w_start) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Datapath: operand latch at start, one step per RUN cycle, HI/LO written only at completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_rem      <= '0;
         r_q        <= '0;
         r_div      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_busy <= (w_next_state == RUN);
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_q   <= w_a_op;
                  r_div <= w_b_op;
                  r_rem <= '0;
                  r_cnt <= '0;
               end
            end
            RUN: begin
               r_rem <= w_rem_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_hi       <= w_hi_fin;
                  r_lo       <= w_lo_fin;
                  r_div_zero <= (r_div == '0);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DIVU_SIGNED_DIV_EN
   // Sign flags latched alongside the operands; DIVU clears them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if ((r_state == IDLE) && w_start) begin
         r_neg_q <= w_is_div && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
         r_neg_r <= w_is_div && dataA[WIDTH-1];
      end
   end
`endif

   // Read-back mux: HI for MFHI, LO for MFLO, zero otherwise.
   always_comb begin
      Output = '0;
      case (Signal)
         FN_MFHI: Output = r_hi;
         FN_MFLO: Output = r_lo;
         default: Output = '0;
      endcase
   end

   assign busy     = r_busy;
   assign div_zero = r_div_zero;

endmodule

// File: tb/tb_divu_unit.sv
// Bench for divu_unit: directed vectors, arithmetic reference model, per-cycle output compare.
module tb_divu_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dataA = '0;
   logic [31:0] dataB = '0;
   logic [5:0]  Signal = '0;
   logic [31:0] Output;
   logic        busy;
   logic        div_zero;

   int n_checks = 0;
   int n_err    = 0;

   divu_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .dataA    (dataA),
      .dataB    (dataB),
      .Signal   (Signal),
      .Output   (Output),
      .busy     (busy),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic is_start(input logic [5:0] s);
`ifdef DIVU_SIGNED_DIV_EN
      return (s == 6'd27) || (s == 6'd26);
`else
      return (s == 6'd27);
`endif
   endfunction

   // Reference model: a division takes 32 edges, results from plain arithmetic.
   logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
   logic        m_dz = 1'b0, m_busy = 1'b0, m_hold = 1'b0, m_sgn = 1'b0;
   int          m_left = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi = '0; m_lo = '0; m_dz = 1'b0; m_busy = 1'b0; m_hold = 1'b0; m_left = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_hold = 1'b1;
            if (m_b == 0) begin
               m_lo = 32'hFFFF_FFFF; m_hi = m_a; m_dz = 1'b1;
            end else if (m_sgn) begin
               m_lo = $signed(m_a) / $signed(m_b); m_hi = $signed(m_a) % $signed(m_b); m_dz = 1'b0;
            end else begin
               m_lo = m_a / m_b; m_hi = m_a % m_b; m_dz = 1'b0;
            end
         end
      end else if (m_hold) begin
         if (!is_start(Signal)) m_hold = 1'b0;
      end else if (is_start(Signal)) begin
         m_busy = 1'b1; m_left = 32; m_a = dataA; m_b = dataB; m_sgn = (Signal == 6'd26);
      end
   end

   function automatic logic [31:0] exp_out(input logic [5:0] s);
      if (s == 6'd16) return m_hi;
      if (s == 6'd18) return m_lo;
      return 32'h0;
   endfunction

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cyc_div_zero", {31'b0, div_zero}, {31'b0, m_dz});
      chk("cyc_output", Output, exp_out(Signal));
   end

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig);
      @(posedge clk); #1;
      dataA = a; dataB = b; Signal = sig;
      @(posedge clk); #1;
      Signal = 6'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("wait_busy_low", {31'b0, busy}, 32'h0);
   endtask

   task automatic read_back(input string name, input logic [31:0] hi, input logic [31:0] lo,
                            input logic dz);
      @(posedge clk); #1 Signal = 6'd16;
      @(negedge clk); chk({name, "_hi"}, Output, hi);
      @(posedge clk); #1 Signal = 6'd18;
      @(negedge clk); chk({name, "_lo"}, Output, lo);
      chk({name, "_dz"}, {31'b0, div_zero}, {31'b0, dz});
      @(posedge clk); #1 Signal = 6'd0;
   endtask

   int busy_cnt;
   int starts;
   logic prev_busy;

   initial begin
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      chk("reset_busy", {31'b0, busy}, 32'h0);
      chk("reset_div_zero", {31'b0, div_zero}, 32'h0);
      Signal = 6'd16;
      @(negedge clk); chk("reset_mfhi", Output, 32'h0);
      @(posedge clk); #1 Signal = 6'd18;
      @(negedge clk); chk("reset_mflo", Output, 32'h0);

      // 100 / 7 with the start code held for 33 edges.
      @(posedge clk); #1;
      dataA = 32'd100; dataB = 32'd7; Signal = 6'd27;
      busy_cnt = 0; starts = 0; prev_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (busy && !prev_busy) starts++;
         prev_busy = busy;
         @(posedge clk); #1;
         if (i == 32) Signal = 6'd0;
      end
      chk("held_busy_cycles", busy_cnt, 32'd32);
      chk("held_single_start", starts, 32'd1);
      chk("model_hi_100_7", m_hi, 32'd2);
      chk("model_lo_100_7", m_lo, 32'd14);
      read_back("d100_7", 32'd2, 32'd14, 1'b0);

      run_div(32'hFFFF_FFFF, 32'd1, 6'd27);
      read_back("dmax_1", 32'd0, 32'hFFFF_FFFF, 1'b0);
      run_div(32'd3, 32'd10, 6'd27);
      read_back("d3_10", 32'd3, 32'd0, 1'b0);
      run_div(32'd5, 32'd0, 6'd27);
      chk("model_lo_5_0", m_lo, 32'hFFFF_FFFF);
      read_back("d5_0", 32'd5, 32'hFFFF_FFFF, 1'b1);
      run_div(32'd9, 32'd3, 6'd27);
      read_back("d9_3", 32'd0, 32'd3, 1'b0);

      // Abort by reset mid-run.
      run_div(32'd100, 32'd7, 6'd27);
      @(posedge clk); #1;
      dataA = 32'd1000; dataB = 32'd3; Signal = 6'd27;
      @(posedge clk); #1 Signal = 6'd0;
      repeat (9) @(posedge clk);
      #1 Signal = 6'd18;
      @(negedge clk);
      chk("run_mflo_old", Output, 32'd14);
      chk("run_busy", {31'b0, busy}, 32'h1);
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_lo", Output, 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      read_back("after_abort", 32'd0, 32'd0, 1'b0);
      run_div(32'd1000, 32'd3, 6'd27);
      read_back("d1000_3", 32'd1, 32'd333, 1'b0);

`ifdef DIVU_SIGNED_DIV_EN
      run_div(32'hFFFF_FFF9, 32'd2, 6'd26);
      read_back("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
`else
      run_div(32'hFFFF_FFF9, 32'd2, 6'd26);
      read_back("code26_ignored", 32'd1, 32'd333, 1'b0);
`endif

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
